// File: rtl/psum_accum_ctrl_if.sv
// Bundle of the product stream, drain stream and scratchpad port of psum_accum_ctrl.
// The master modport is the controller side; the slave modport is the surrounding fabric.
interface psum_accum_ctrl_if #(
   parameter int ADDR_LEN      = 8,
   parameter int SCRATCH_WIDTH = 16,
   parameter int IN_W          = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [ADDR_LEN-1:0]      in_addr;
   logic [IN_W-1:0]          in_data;
   logic                     in_first;
   logic                     drain_start;
   logic                     drain_clear;
   logic                     out_valid;
   logic                     out_ready;
   logic [ADDR_LEN-1:0]      out_addr;
   logic [SCRATCH_WIDTH-1:0] out_data;
   logic                     drain_done;
   logic                     err_oob;
   logic                     sp_wen;
   logic [ADDR_LEN-1:0]      sp_waddr;
   logic [ADDR_LEN-1:0]      sp_raddr;
   logic [SCRATCH_WIDTH-1:0] sp_din;
   logic [SCRATCH_WIDTH-1:0] sp_dout;

   modport master (
      input  in_valid, in_addr, in_data, in_first, drain_start, drain_clear, out_ready, sp_dout,
      output in_ready, out_valid, out_addr, out_data, drain_done, err_oob,
             sp_wen, sp_waddr, sp_raddr, sp_din
   );

   modport slave (
      output in_valid, in_addr, in_data, in_first, drain_start, drain_clear, out_ready, sp_dout,
      input  in_ready, out_valid, out_addr, out_data, drain_done, err_oob,
             sp_wen, sp_waddr, sp_raddr, sp_din
   );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write accumulator controller for the partial-sum scratchpad, with ordered drain.
// Define PSUM_SATURATE_EN for saturating accumulation; the default build wraps modulo 2^SCRATCH_WIDTH.
module psum_accum_ctrl #(
   parameter int ADDR_LEN      = 8,
   parameter int SCRATCH_DEPTH = 8,
   parameter int SCRATCH_WIDTH = 16,
   parameter int IN_W          = 8
) (
   input logic               clk,
   input logic               rst_n,
   psum_accum_ctrl_if.master bus
);
   localparam int W = SCRATCH_WIDTH;
   localparam logic [ADDR_LEN:0]   DEPTH_EXT = (ADDR_LEN+1)'(SCRATCH_DEPTH);
   localparam logic [ADDR_LEN-1:0] LAST_IDX  = ADDR_LEN'(SCRATCH_DEPTH - 1);

   typedef enum logic [2:0] {ACC, FLUSH, DRAIN_RD, DRAIN_OUT, DONE} state_t;
   state_t state, state_nxt;

   logic                       b_valid;
   logic [ADDR_LEN-1:0]        b_addr;
   logic signed [IN_W-1:0]     b_data;
   logic                       b_first;
   logic                       fwd_valid;
   logic [ADDR_LEN-1:0]        fwd_addr;
   logic signed [W-1:0]        fwd_data;
   logic                       clear_q;
   logic                       err_q;
   logic [ADDR_LEN-1:0]        k;
   logic                       out_first;
   logic [W-1:0]               out_hold;

   logic                       in_fire;
   logic                       in_oob;
   logic                       drain_fire;
   logic                       out_fire;
   logic signed [W-1:0]        old_val;
   logic signed [W:0]          wide;
   logic signed [W-1:0]        sum;

   assign in_fire    = (state == ACC) && bus.in_valid;
   assign in_oob     = {1'b0, bus.in_addr} >= DEPTH_EXT;
   assign drain_fire = (state == ACC) && bus.drain_start;
   assign out_fire   = (state == DRAIN_OUT) && bus.out_ready;
   assign bus.err_oob = err_q;

   // The write issued last cycle lands on the same edge as this entry's read, so take it from the bypass.
   always_comb begin
      old_val = (fwd_valid && (fwd_addr == b_addr)) ? fwd_data : $signed(bus.sp_dout);
      if (b_first) old_val = '0;
      wide = (W+1)'(old_val) + (W+1)'(b_data);
      sum  = wide[W-1:0];
`ifdef PSUM_SATURATE_EN
      if (wide[W] != wide[W-1])
         sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid   <= 1'b0;
         b_addr    <= '0;
         b_data    <= '0;
         b_first   <= 1'b0;
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_data  <= '0;
         clear_q   <= 1'b0;
         err_q     <= 1'b0;
         k         <= '0;
         out_first <= 1'b0;
         out_hold  <= '0;
      end else begin
         b_valid <= in_fire && !in_oob;
         if (in_fire) begin
            b_addr  <= bus.in_addr;
            b_data  <= bus.in_data;
            b_first <= bus.in_first;
         end
         fwd_valid <= b_valid;
         if (b_valid) begin
            fwd_addr <= b_addr;
            fwd_data <= sum;
         end
         if (in_fire && in_oob)  err_q <= 1'b1;
         else if (drain_fire)    err_q <= 1'b0;
         if (drain_fire) clear_q <= bus.drain_clear;
         if (state == FLUSH)                      k <= '0;
         else if (out_fire && (k != LAST_IDX))    k <= k + ADDR_LEN'(1);
         out_first <= (state == DRAIN_RD);
         if (out_first) out_hold <= bus.sp_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:       if (drain_fire) state_nxt = FLUSH;
         FLUSH:     state_nxt = DRAIN_RD;
         DRAIN_RD:  state_nxt = DRAIN_OUT;
         DRAIN_OUT: if (bus.out_ready) state_nxt = (k == LAST_IDX) ? DONE : DRAIN_RD;
         DONE:      state_nxt = ACC;
         default:   state_nxt = ACC;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      bus.in_ready   = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_addr   = '0;
      bus.out_data   = '0;
      bus.drain_done = 1'b0;
      bus.sp_raddr   = '0;
      bus.sp_wen     = b_valid;
      bus.sp_waddr   = b_valid ? b_addr : '0;
      bus.sp_din     = b_valid ? sum : '0;
      case (state)
         ACC: begin
            bus.in_ready = 1'b1;
            bus.sp_raddr = bus.in_valid ? bus.in_addr : '0;
         end
         DRAIN_RD: bus.sp_raddr = k;
         DRAIN_OUT: begin
            bus.out_valid = 1'b1;
            bus.out_addr  = k;
            bus.out_data  = out_first ? bus.sp_dout : out_hold;
            bus.sp_raddr  = k;
            if (out_fire && clear_q) begin
               bus.sp_wen   = 1'b1;
               bus.sp_waddr = k;
               bus.sp_din   = '0;
            end
         end
         DONE:    bus.drain_done = 1'b1;
         default: ;
      endcase
   end
endmodule
